// File: rtl/cds_pkg.sv
// Shared definitions for the CDS readout sequencer: FSM state encoding,
// default timing constants and a counter-width helper.
package cds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW_SETTLE,
    TRIG,
    WAIT_CDS,
    ADC,
    WAIT_ADC,
    DONE
  } cds_state_t;

  localparam int DEFAULT_SETTLE_CYCLES  = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  // Bits needed to hold any value from 0 up to max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/cds_seq_watchdog.sv
// Handshake watchdog for the CDS readout sequencer; only compiled when
// CDS_SEQ_TIMEOUT_EN is defined.
`ifdef CDS_SEQ_TIMEOUT_EN
module cds_seq_watchdog
  import cds_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == LAST);

  // Counts consecutive waiting cycles; restarts whenever the wait ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || expired) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/cds_readout_sequencer.sv
// Row/column readout sequencer driving a CDS clock generator and an ADC.
// Optional handshake watchdog enabled by defining CDS_SEQ_TIMEOUT_EN.
module cds_readout_sequencer
  import cds_pkg::*;
#(
  parameter int ROW_W          = 8,
  parameter int COL_W          = 8,
  parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [COL_W-1:0] num_cols,
  input  logic             cds_done,
  input  logic             adc_done,
  output logic             cds_trigger,
  output logic             adc_start,
  output logic             row_sel,
  output logic [ROW_W-1:0] row_addr,
  output logic [COL_W-1:0] col_addr,
  output logic             busy,
  output logic             frame_done,
  output logic             seq_error
);

  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  cds_state_t       state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [COL_W-1:0] cols_q, cols_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             gap_q, gap_d;
  logic             timeout;

`ifdef CDS_SEQ_TIMEOUT_EN
  logic waiting;
  logic err_q;

  assign waiting   = (state_q == WAIT_CDS) || (state_q == WAIT_ADC);
  assign seq_error = err_q;

  cds_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (waiting),
    .expired(timeout)
  );

  // Sticky until the next accepted frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if (!abort && (state_q == IDLE) && start) begin
      err_q <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  // Constant low; the term only keeps TIMEOUT_CYCLES referenced.
  assign seq_error = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      settle_q <= '0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    gap_d    = gap_q;

    busy        = (state_q != IDLE);
    cds_trigger = (state_q == TRIG);
    adc_start   = (state_q == ADC);
    frame_done  = (state_q == DONE);
    row_sel     = ((state_q == ROW_SETTLE) && !gap_q) || (state_q == TRIG) ||
                  (state_q == WAIT_CDS) || (state_q == ADC) || (state_q == WAIT_ADC);
    row_addr    = row_q;
    col_addr    = col_q;

    if (abort || timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rows_d   = num_rows;
            cols_d   = num_cols;
            row_d    = '0;
            col_d    = '0;
            settle_d = '0;
            gap_d    = 1'b0;
            state_d  = ((num_rows == '0) || (num_cols == '0)) ? DONE : ROW_SETTLE;
          end
        end
        // A row change first spends one cycle with row_sel low, then settles.
        ROW_SETTLE: begin
          if (gap_q) begin
            gap_d = 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = TRIG;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        TRIG: state_d = WAIT_CDS;
        WAIT_CDS: begin
          if (cds_done) state_d = ADC;
        end
        ADC: state_d = WAIT_ADC;
        WAIT_ADC: begin
          if (adc_done) begin
            if (col_q != cols_q - COL_W'(1)) begin
              col_d   = col_q + COL_W'(1);
              state_d = TRIG;
            end else if (row_q != rows_q - ROW_W'(1)) begin
              row_d    = row_q + ROW_W'(1);
              col_d    = '0;
              settle_d = '0;
              gap_d    = 1'b1;
              state_d  = ROW_SETTLE;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
